// File: rtl/stim_sweep.sv
// rtl/stim_sweep.sv - operand sweep driver: manual, auto-up, ping-pong and button-step modes
// Issues operands over a valid/ready request channel and captures one result per operand.
module stim_sweep #(
  parameter int N    = 16,
  parameter int MAXV = 24,
  parameter int DIVW = 27,
  parameter int SELW = 5
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [1:0]      mode,
  input  logic [SELW-1:0] sel,
  input  logic            step,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [N-1:0]    req_data,
  input  logic            resp_valid,
  output logic            resp_ready,
  input  logic [N-1:0]    resp_data,
  output logic [N-1:0]    out_data,
  output logic [N-1:0]    out_operand,
  output logic            busy,
  output logic            miss
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  localparam logic [1:0]      MODE_MAN  = 2'd0;
  localparam logic [1:0]      MODE_UP   = 2'd1;
  localparam logic [1:0]      MODE_PING = 2'd2;
  localparam logic [1:0]      MODE_STEP = 2'd3;
  localparam logic [N-1:0]    MAX_A     = N'(MAXV);
  localparam logic [N-1:0]    ONE       = N'(1);
  localparam logic [DIVW-1:0] DIV_ONE   = DIVW'(1);

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic            dir_q, dir_d;          // 0 = up, 1 = down
  logic [DIVW-1:0] div_q, div_d;
  logic [1:0]      mode_q;
  logic [2:0]      sync_q;
  logic [N-1:0]    req_data_q, req_data_d;
  logic [N-1:0]    out_data_q, out_data_d;
  logic [N-1:0]    out_operand_q, out_operand_d;
  logic            miss_q, miss_d;

  logic [N-1:0]    sel_ext, a_inc, a_dec, nxt_a;
  logic            nxt_dir, mode_chg, auto_mode, tick, step_evt, man_evt, auto_evt, idle, launch;

  // sync_q[1:0] is the synchronizer; sync_q[2] only remembers the previous level for edge detect
  assign step_evt  = sync_q[1] & ~sync_q[2];
  assign mode_chg  = (mode != mode_q);
  assign auto_mode = (mode_q == MODE_UP) || (mode_q == MODE_PING);
  assign tick      = auto_mode && (div_q == '0);
  assign sel_ext   = N'(sel);
  assign a_inc     = a_q + ONE;
  assign a_dec     = a_q - ONE;
  assign idle      = (state_q == S_IDLE);
  assign man_evt   = (mode_q == MODE_MAN) && (sel_ext != a_q) && (sel_ext <= MAX_A) && !mode_chg;
  // Events are dropped on the cycle a new mode is being taken so they never mix old and new modes
  assign auto_evt  = (tick || ((mode_q == MODE_STEP) && step_evt)) && !mode_chg;

  always_comb begin
    nxt_a   = a_q;
    nxt_dir = dir_q;
    case (mode_q)
      MODE_PING: begin
        if (!dir_q) begin
          if (a_q == MAX_A) begin
            nxt_dir = 1'b1;
            nxt_a   = (MAX_A == '0) ? '0 : a_dec;
          end else begin
            nxt_a   = a_inc;
            nxt_dir = (a_inc == MAX_A);
          end
        end else begin
          if (a_q == '0) begin
            nxt_dir = 1'b0;
            nxt_a   = (MAX_A == '0) ? '0 : a_inc;
          end else begin
            nxt_a   = a_dec;
            nxt_dir = (a_dec != '0);
          end
        end
      end
      default: nxt_a = (a_q == MAX_A) ? '0 : a_inc;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    dir_d         = dir_q;
    div_d         = auto_mode ? (div_q + DIV_ONE) : '0;
    req_data_d    = req_data_q;
    out_data_d    = out_data_q;
    out_operand_d = out_operand_q;
    miss_d        = miss_q;
    launch        = 1'b0;

    if (idle) begin
      if (man_evt) begin
        a_d    = sel_ext;
        launch = 1'b1;
      end else if (auto_evt) begin
        a_d    = nxt_a;
        dir_d  = nxt_dir;
        launch = 1'b1;
      end
    end else if (auto_evt) begin
      miss_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (launch) begin
        state_d    = S_REQ;
        req_data_d = a_d;
      end
      S_REQ:  if (req_ready) state_d = S_WAIT;
      S_WAIT: if (resp_valid) begin
        out_data_d    = resp_data;
        out_operand_d = req_data_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (mode_chg) begin
      miss_d = 1'b0;
      dir_d  = 1'b0;
      div_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      a_q           <= '0;
      dir_q         <= 1'b0;
      div_q         <= '0;
      mode_q        <= MODE_MAN;
      sync_q        <= '0;
      req_data_q    <= '0;
      out_data_q    <= '0;
      out_operand_q <= '0;
      miss_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      dir_q         <= dir_d;
      div_q         <= div_d;
      mode_q        <= mode;
      sync_q        <= {sync_q[1:0], step};
      req_data_q    <= req_data_d;
      out_data_q    <= out_data_d;
      out_operand_q <= out_operand_d;
      miss_q        <= miss_d;
    end
  end

  assign req_valid   = (state_q == S_REQ);
  assign resp_ready  = (state_q == S_WAIT);
  assign busy        = (state_q != S_IDLE);
  assign req_data    = req_data_q;
  assign out_data    = out_data_q;
  assign out_operand = out_operand_q;
  assign miss        = miss_q;

endmodule

// File: tb/tb_stim_sweep.sv
// tb/tb_stim_sweep.sv - directed and randomized bench for stim_sweep
// Core model: always ready unless held, answers operand*2 two cycles after accept.
module tb_stim_sweep;

  logic        clk;
  logic        nrst;
  logic [1:0]  mode;
  logic [4:0]  sel;
  logic        step;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [15:0] out_data;
  logic [15:0] out_operand;
  logic        busy;
  logic        miss;

  int checks   = 0;
  int failures = 0;
  int cycle_cnt = 0;
  int pend = 0;
  logic [15:0] core_op;
  logic [15:0] issued[$];
  int          stamps[$];

  stim_sweep #(.N(16), .MAXV(24), .DIVW(3), .SELW(5)) dut (
    .clk(clk), .nrst(nrst), .mode(mode), .sel(sel), .step(step),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .out_data(out_data), .out_operand(out_operand), .busy(busy), .miss(miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  always @(negedge clk) begin
    resp_valid = 1'b0;
    if (pend != 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        resp_valid = 1'b1;
        resp_data  = 16'(core_op * 2);
      end
    end
    if (req_valid && req_ready) begin
      core_op = req_data;
      pend    = 2;
      issued.push_back(req_data);
      stamps.push_back(cycle_cnt);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_issues(input int target, input int budget, input string tag);
    int n = 0;
    while (issued.size() < target && n < budget) begin
      cyc(1);
      n++;
    end
    check(tag, 32'(issued.size() >= target), 32'd1);
  endtask

  task automatic go_manual();
    sel  = 5'd30;
    mode = 2'd0;
    cyc(6);
  endtask

  function automatic int tri_val(input int p);
    int q = p % 48;
    return (q <= 24) ? q : 48 - q;
  endfunction

  function automatic int gap_errors(input int from, input int to);
    int bad = 0;
    for (int k = from + 1; k < to; k++)
      if (stamps[k] - stamps[k-1] != 8) bad++;
    return bad;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, model_a, exp_cnt, s, x, w, n, v;
    nrst = 1'b0; mode = 2'd0; sel = 5'd0; step = 1'b0; req_ready = 1'b1;
    resp_valid = 1'b0; resp_data = 16'd0;
    cyc(3);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_data", 32'(req_data), 32'd0);
    check("rst_resp_ready", 32'(resp_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_operand", 32'(out_operand), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    nrst = 1'b1;
    cyc(2);
    check("idle_no_launch", 32'(issued.size()), 32'd0);

    // Manual select of 5 launches one cycle later
    base = issued.size();
    sel = 5'd5;
    cyc(1);
    check("m0_req_valid", 32'(req_valid), 32'd1);
    check("m0_req_data", 32'(req_data), 32'd5);
    cyc(4);
    check("m0_out_data", 32'(out_data), 32'd10);
    check("m0_out_operand", 32'(out_operand), 32'd5);
    check("m0_busy", 32'(busy), 32'd0);
    check("m0_count", 32'(issued.size()), 32'(base + 1));
    model_a = 5;

    // Out-of-range select is ignored
    sel = 5'd30;
    cyc(10);
    check("m0_oor_count", 32'(issued.size()), 32'(base + 1));
    check("m0_oor_valid", 32'(req_valid), 32'd0);

    exp_cnt = issued.size();
    for (int i = 0; i < 8; i++) begin
      s = int'($urandom_range(0, 31));
      sel = 5'(s);
      cyc(8);
      if (s <= 24 && s != model_a) begin
        exp_cnt++;
        model_a = s;
      end
      check("m0_rand_count", 32'(issued.size()), 32'(exp_cnt));
      check("m0_rand_operand", 32'(out_operand), 32'(model_a));
      check("m0_rand_data", 32'(out_data), 32'(model_a * 2));
    end
    sel = 5'd24;
    cyc(8);
    model_a = 24;
    check("m0_preset24", 32'(out_operand), 32'd24);

    // Auto-up: 26 operands 0..24,0 every 8 cycles
    base = issued.size();
    mode = 2'd1;
    wait_issues(base + 26, 260, "m1_issue_timeout");
    for (int k = 0; k < 26; k++)
      check("m1_seq", 32'(issued[base + k]), 32'((model_a + 1 + k) % 25));
    check("m1_gaps", 32'(gap_errors(base, base + 26)), 32'd0);
    check("m1_miss", 32'(miss), 32'd0);
    model_a = (model_a + 26) % 25;
    go_manual();

    // Ping-pong: triangle wave between 0 and 24
    base = issued.size();
    mode = 2'd2;
    wait_issues(base + 50, 420, "m2_issue_timeout");
    for (int k = 0; k < 50; k++)
      check("m2_seq", 32'(issued[base + k]), 32'(tri_val(model_a + 1 + k)));
    check("m2_gaps", 32'(gap_errors(base, base + 50)), 32'd0);
    model_a = tri_val(model_a + 50);
    go_manual();

    // Auto-up with the core stalled: request held, ticks dropped
    base = issued.size();
    x = (model_a + 1) % 25;
    req_ready = 1'b0;
    mode = 2'd1;
    cyc(5);
    check("stall_valid_early", 32'(req_valid), 32'd1);
    check("stall_data_early", 32'(req_data), 32'(x));
    cyc(15);
    check("stall_valid_late", 32'(req_valid), 32'd1);
    check("stall_data_late", 32'(req_data), 32'(x));
    check("stall_miss", 32'(miss), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_no_accept", 32'(issued.size()), 32'(base));
    req_ready = 1'b1;
    wait_issues(base + 2, 40, "stall_issue_timeout");
    check("stall_first", 32'(issued[base]), 32'(x));
    check("stall_next", 32'(issued[base + 1]), 32'((x + 1) % 25));
    check("stall_miss_sticky", 32'(miss), 32'd1);
    model_a = (x + 1) % 25;
    mode = 2'd3;
    cyc(2);
    check("mode_clears_miss", 32'(miss), 32'd0);
    cyc(6);

    // Button step: a long press launches once
    base = issued.size();
    step = 1'b1;
    cyc(10);
    step = 1'b0;
    cyc(10);
    v = (model_a + 1) % 25;
    check("step_count", 32'(issued.size()), 32'(base + 1));
    check("step_operand", 32'(issued[base]), 32'(v));
    check("step_out_data", 32'(out_data), 32'(v * 2));
    model_a = v;

    // Reset while waiting for the response
    base = issued.size();
    w = int'($urandom_range(1, 3));
    step = 1'b1;
    cyc(w);
    step = 1'b0;
    n = 0;
    while (!resp_ready && n < 20) begin
      cyc(1);
      n++;
    end
    check("rst_wait_reached", 32'(resp_ready), 32'd1);
    check("rst_wait_launched", 32'(issued.size()), 32'(base + 1));
    nrst = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_valid", 32'(req_valid), 32'd0);
    check("arst_req_data", 32'(req_data), 32'd0);
    check("arst_resp_ready", 32'(resp_ready), 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_out_operand", 32'(out_operand), 32'd0);
    check("arst_miss", 32'(miss), 32'd0);
    cyc(3);
    nrst = 1'b1;
    cyc(5);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_out_data", 32'(out_data), 32'd0);
    check("post_rst_resp_ready", 32'(resp_ready), 32'd0);

    // Operand restarts from 0 after reset
    base = issued.size();
    step = 1'b1;
    cyc(3);
    step = 1'b0;
    wait_issues(base + 1, 20, "post_rst_issue_timeout");
    cyc(4);
    check("post_rst_operand", 32'(issued[base]), 32'd1);
    check("post_rst_result", 32'(out_data), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stim_sweep.md
STIM_SWEEP -- requirements
Module: stim_sweep

Interface
REQ-001 Parameter N, default 16, operand/result width in bits.
REQ-002 Parameter MAXV, default 24, largest operand issued; must be < 2^N.
REQ-003 Parameter DIVW, default 27, auto-step divider width.
REQ-004 Parameter SELW, default 5, manual select width; SELW <= N.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 nrst  input  1  reset, asynchronous, active-low.
REQ-007 mode  input  2  0 manual, 1 auto-up, 2 ping-pong, 3 button-step.
REQ-008 sel  input  SELW  manual operand from switches, zero-extended to N.
REQ-009 step  input  1  asynchronous button, used in mode 3.
REQ-010 req_valid  output  1  operand offered to the generated core.
REQ-011 req_ready  input  1  core accepts the operand.
REQ-012 req_data  output  N  operand.
REQ-013 resp_valid  input  1  core result valid.
REQ-014 resp_ready  output  1  driver accepts the result.
REQ-015 resp_data  input  N  core result.
REQ-016 out_data  output  N  last captured result, held.
REQ-017 out_operand  output  N  operand that produced out_data.
REQ-018 busy  output  1  transaction in flight.
REQ-019 miss  output  1  sticky: an auto or step event was dropped.

Function
REQ-020 step SHALL pass a 2-flop synchronizer; step_evt is a one-cycle pulse on a synchronized 0->1 edge.
REQ-021 Divider div (DIVW bits) SHALL increment every cycle in modes 1 and 2, wrap at 2^DIVW, and hold 0 in modes 0 and 3.
REQ-022 tick SHALL be asserted on any cycle with div==0 in mode 1 or 2, so the first tick falls on the first cycle after entry into an auto mode.
REQ-023 FSM states SHALL be IDLE, REQ and WAIT; busy = (state != IDLE).
REQ-024 Mode 0: in IDLE, when sel != a and sel <= MAXV, a <= sel and a launch occurs; sel > MAXV SHALL be ignored; while busy the comparison simply retries and no miss is raised.
REQ-025 Mode 1: on tick, a <= (a==MAXV) ? 0 : a+1, then launch.
REQ-026 Mode 2: on tick, while dir is up, a increments until it reaches MAXV, then dir flips to down; while dir is down, a decrements until it reaches 0, then dir flips to up. Sequence: 0,1..MAXV,MAXV-1..0,1.
REQ-027 Mode 3: on step_evt, a <= (a==MAXV) ? 0 : a+1, then launch.
REQ-028 Launch, IDLE only: state <= REQ, req_data <= new a, and req_valid is high from the next cycle (1-cycle latency).
REQ-029 If a tick or step_evt occurs while busy, a and dir SHALL NOT change and miss SHALL be set.
REQ-030 REQ: req_valid=1 and req_data stable until the cycle req_ready=1, then state <= WAIT.
REQ-031 WAIT: resp_ready=1; on resp_valid, out_data <= resp_data, out_operand <= req_data, state <= IDLE.
REQ-032 resp_ready SHALL be 0 outside WAIT; resp_valid outside WAIT is ignored.
REQ-033 A mode change SHALL clear miss, set dir up and clear div; an in-flight transaction SHALL complete normally.
REQ-034 When MAXV==0, a stays at 0 and every event still launches.

Reset
REQ-035 While nrst=0, state SHALL be IDLE and the following SHALL all be 0: a, div, dir (up), req_valid, req_data, resp_ready, out_data, out_operand, busy, miss, and the synchronizer flops.
REQ-036 When nrst is asserted mid-transaction, the transaction is abandoned immediately; after release, no response is awaited.

Verification (bench uses DIVW=3, MAXV=24; the core model has req_ready=1 and resp_valid 2 cycles after accept, returning operand*2)
REQ-037 Mode 0, sel=5 from reset -> req_valid with req_data=5 one cycle later; then out_data=10, out_operand=5, busy=0.
REQ-038 Mode 0, sel=30 -> no req_valid; a stays at its prior value.
REQ-039 Mode 1, 200 cycles -> operands issue every 8 cycles as 0..24,0 (wrap after 24); miss=0.
REQ-040 Mode 2 -> operand sequence 0,1..24,23..0,1; dir flips exactly at 24 and at 0.
REQ-041 Mode 1 with core req_ready held 0 for 20 cycles -> req_data held and req_valid held; miss=1; after release the sequence continues from the held operand +1; a mode write clears miss.
REQ-042 Mode 3: one step pulse 10 cycles wide -> exactly one launch; nrst pulsed low while in WAIT -> all outputs 0 and state IDLE.
